// File: rtl/cello_sweep_pkg.sv
// Shared constants and FSM encoding for the truth-table sweeper.
package cello_sweep_pkg;

  localparam int unsigned ROW_W   = 3;
  localparam int unsigned TABLE_W = 8;
  localparam int unsigned CNT_W   = 8;

  // Last row code; the sweep ends after sampling it.
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(TABLE_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } sweep_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
//   clk : sampling clock
//   rst : synchronous active-high reset, clears both flops
//   d   : asynchronous input
//   q   : synchronized output (two cycles of latency)
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps all eight input codes of a downstream 3-input logic block, captures
// its response into a truth table and compares it against a golden table.
//   clk, rst        : clock and synchronous active-high reset
//   start           : one-cycle pulse starting a sweep (ignored while busy)
//   in1, in2, in3   : stimulus to the logic block, in1 is the row MSB
//   dut_out         : asynchronous response of the logic block
//   busy            : sweep in progress
//   done            : one-cycle pulse when the sweep completes
//   truth_table     : captured table, MSB = row 000
//   mismatch        : truth_table XOR EXPECTED, valid from done onward
//   pass            : mismatch == 0, valid from done onward
module truth_table_sweeper
  import cello_sweep_pkg::*;
#(
  parameter int unsigned        SETTLE_CYCLES = 4,
  parameter logic [TABLE_W-1:0] EXPECTED      = 8'hFC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               in1,
  output logic               in2,
  output logic               in3,
  input  logic               dut_out,
  output logic               busy,
  output logic               done,
  output logic [TABLE_W-1:0] truth_table,
  output logic [TABLE_W-1:0] mismatch,
  output logic               pass
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  sweep_state_t       state, state_nxt;
  logic [ROW_W-1:0]   row, row_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [ROW_W-1:0]   code_nxt;
  logic [TABLE_W-1:0] table_nxt, mismatch_nxt;
  logic               pass_nxt, done_nxt, busy_nxt;
  logic               resp;

  // Response is only ever consumed after synchronization.
  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (dut_out),
    .q   (resp)
  );

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      row             <= '0;
      cnt             <= '0;
      truth_table     <= '0;
      mismatch        <= '0;
      pass            <= 1'b0;
      done            <= 1'b0;
      busy            <= 1'b0;
      {in1, in2, in3} <= '0;
    end else begin
      state           <= state_nxt;
      row             <= row_nxt;
      cnt             <= cnt_nxt;
      truth_table     <= table_nxt;
      mismatch        <= mismatch_nxt;
      pass            <= pass_nxt;
      done            <= done_nxt;
      busy            <= busy_nxt;
      {in1, in2, in3} <= code_nxt;
    end
  end

  // Next-state and next-output logic; outputs are computed for the state
  // being entered so that the registered values line up with that state.
  always_comb begin
    state_nxt    = state;
    row_nxt      = row;
    cnt_nxt      = cnt;
    table_nxt    = truth_table;
    mismatch_nxt = mismatch;
    pass_nxt     = pass;
    done_nxt     = 1'b0;
    busy_nxt     = 1'b1;
    code_nxt     = '0;

    case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        if (start) begin
          table_nxt = '0;
          row_nxt   = '0;
          cnt_nxt   = '0;
          busy_nxt  = 1'b1;
          state_nxt = APPLY;
        end
      end

      APPLY: begin
        code_nxt = row;
        if (cnt == CNT_LAST) begin
          state_nxt = SAMPLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      SAMPLE: begin
        // Row 000 lands in the MSB of the table.
        table_nxt[ROW_LAST - row] = resp;
        if (row == ROW_LAST) begin
          state_nxt    = FINISH;
          done_nxt     = 1'b1;
          mismatch_nxt = table_nxt ^ EXPECTED;
          pass_nxt     = (table_nxt == EXPECTED);
        end else begin
          row_nxt   = row + ROW_W'(1);
          cnt_nxt   = '0;
          code_nxt  = row + ROW_W'(1);
          state_nxt = APPLY;
        end
      end

      FINISH: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end

      default: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench: two sweepers (settle 4 and settle 3) each driving a
// behavioural logic block with an optional response delay.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_a, start_b;
  logic       in1_a, in2_a, in3_a, in1_b, in2_b, in3_b;
  logic       dut_out_a, dut_out_b;
  logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [7:0] table_a, table_b, mm_a, mm_b;

  logic [7:0] tt_model;
  int         dly;
  int         sel;
  int         checks   = 0;
  int         failures = 0;

  truth_table_sweeper #(.SETTLE_CYCLES(4), .EXPECTED(8'hFC)) u_a (
    .clk(clk), .rst(rst), .start(start_a),
    .in1(in1_a), .in2(in2_a), .in3(in3_a), .dut_out(dut_out_a),
    .busy(busy_a), .done(done_a), .truth_table(table_a),
    .mismatch(mm_a), .pass(pass_a)
  );

  truth_table_sweeper #(.SETTLE_CYCLES(3), .EXPECTED(8'hFC)) u_b (
    .clk(clk), .rst(rst), .start(start_b),
    .in1(in1_b), .in2(in2_b), .in3(in3_b), .dut_out(dut_out_b),
    .busy(busy_b), .done(done_b), .truth_table(table_b),
    .mismatch(mm_b), .pass(pass_b)
  );

  // Behavioural logic blocks: truth table lookup plus a cycle delay line.
  logic [2:0] code_a, code_b;
  logic       comb_a, comb_b;
  logic [3:0] hist_a = '0, hist_b = '0;
  assign code_a = {in1_a, in2_a, in3_a};
  assign code_b = {in1_b, in2_b, in3_b};
  assign comb_a = tt_model[3'd7 - code_a];
  assign comb_b = tt_model[3'd7 - code_b];
  always @(posedge clk) begin
    hist_a <= {hist_a[2:0], comb_a};
    hist_b <= {hist_b[2:0], comb_b};
  end
  assign dut_out_a = (dly == 0) ? comb_a : hist_a[dly-1];
  assign dut_out_b = (dly == 0) ? comb_b : hist_b[dly-1];

  // Views of whichever instance is under test.
  logic       cur_busy, cur_done, cur_pass;
  logic [2:0] cur_code;
  logic [7:0] cur_table, cur_mm;
  assign cur_busy  = (sel != 0) ? busy_b  : busy_a;
  assign cur_done  = (sel != 0) ? done_b  : done_a;
  assign cur_pass  = (sel != 0) ? pass_b  : pass_a;
  assign cur_code  = (sel != 0) ? code_b  : code_a;
  assign cur_table = (sel != 0) ? table_b : table_a;
  assign cur_mm    = (sel != 0) ? mm_b    : mm_a;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel != 0) start_b = v;
    else          start_a = v;
  endtask

  // Expected capture: the sample sees the block's output S-1 cycles into the
  // row; with a response delay too long for that, it still shows the
  // previous row's value (row 0 is preceded by code 000 from idle).
  function automatic logic [7:0] ref_table(input logic [7:0] tt, input int s, input int d);
    logic [7:0] res;
    int seen;
    res = '0;
    for (int r = 0; r < 8; r++) begin
      seen = (s - 1 >= d + 1) ? r : ((r == 0) ? 0 : r - 1);
      res[7-r] = tt[7-seen];
    end
    return res;
  endfunction

  // One full sweep on the selected instance; x1/x2 are extra start cycles.
  task automatic run_sweep(input string tag, input int s, input int x1, input int x2,
                           input logic [7:0] exp_tt);
    int lat;
    int done_cnt;
    int done_cyc;
    int q[$];
    bit seq_ok;
    lat      = 8 * (s + 1) + 1;
    done_cnt = 0;
    done_cyc = -1;
    seq_ok   = 1'b1;
    @(negedge clk);
    set_start(1'b1);
    @(posedge clk);
    for (int c = 1; c <= lat + 12; c++) begin
      @(negedge clk);
      if (cur_done) begin
        done_cnt++;
        done_cyc = c;
        if (done_cnt == 1) begin
          check({tag, "_mm_at_done"}, 32'(cur_mm), 32'(exp_tt ^ 8'hFC));
          check({tag, "_pass_at_done"}, 32'(cur_pass), 32'(exp_tt == 8'hFC));
        end
      end else if (cur_busy) begin
        q.push_back(int'(cur_code));
      end
      set_start((c == x1) || (c == x2));
      @(posedge clk);
    end
    foreach (q[i]) if (q[i] != i / (s + 1)) seq_ok = 1'b0;
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, "_done_cyc"}, 32'(done_cyc), 32'(lat));
    check({tag, "_table"}, 32'(cur_table), 32'(exp_tt));
    check({tag, "_mm_hold"}, 32'(cur_mm), 32'(exp_tt ^ 8'hFC));
    check({tag, "_pass_hold"}, 32'(cur_pass), 32'(exp_tt == 8'hFC));
    check({tag, "_busy_idle"}, 32'(cur_busy), 32'd0);
    check({tag, "_code_idle"}, 32'(cur_code), 32'd0);
    check({tag, "_row_cycles"}, 32'(q.size()), 32'(8 * (s + 1)));
    check({tag, "_row_seq"}, 32'(seq_ok), 32'd1);
  endtask

  initial begin
    int abort_done;
    logic [7:0] exp;
    rst      = 1'b1;
    start_a  = 1'b0;
    start_b  = 1'b0;
    tt_model = 8'hFC;
    dly      = 0;
    sel      = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_table", 32'(table_a), 32'd0);
    check("rst_mm", 32'(mm_a), 32'd0);
    check("rst_pass", 32'(pass_a), 32'd0);
    check("rst_code", 32'(code_a), 32'd0);
    check("rst_busy_b", 32'(busy_b), 32'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);

    // Ideal 0xFC block and stuck-at-1 block, settle 4.
    run_sweep("ideal", 4, -1, -1, ref_table(8'hFC, 4, 0));
    tt_model = 8'hFF;
    run_sweep("stuck1", 4, -1, -1, ref_table(8'hFF, 4, 0));
    tt_model = 8'hFC;
    // Extra starts mid-sweep and in the finish cycle are ignored.
    run_sweep("extra_start", 4, 5, 41, ref_table(8'hFC, 4, 0));

    // Reset in cycle 20 together with start: abort, no done, then fresh sweep.
    abort_done = 0;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (done_a) abort_done++;
      start_a = (c == 20);
      rst     = (c == 20);
      @(posedge clk);
    end
    @(negedge clk);
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_table", 32'(table_a), 32'd0);
    check("abort_pass", 32'(pass_a), 32'd0);
    check("abort_code", 32'(code_a), 32'd0);
    rst     = 1'b0;
    start_a = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_a || busy_a) abort_done++;
    end
    check("abort_no_done", 32'(abort_done), 32'd0);
    run_sweep("after_abort", 4, -1, -1, ref_table(8'hFC, 4, 0));

    // Settle 3 instance.
    sel = 1;
    run_sweep("settle3", 3, -1, -1, ref_table(8'hFC, 3, 0));

    // Random truth tables and short response delays on both instances.
    for (int k = 0; k < 6; k++) begin
      sel      = k % 2;
      tt_model = 8'($urandom);
      dly      = int'($urandom_range(0, 1));
      exp      = ref_table(tt_model, (sel != 0) ? 3 : 4, dly);
      run_sweep($sformatf("rand%0d", k), (sel != 0) ? 3 : 4, -1, -1, exp);
    end

    // Two-cycle response delay: tolerated at settle 4, not at settle 3.
    tt_model = 8'hFC;
    dly      = 2;
    repeat (8) @(posedge clk);
    sel = 0;
    run_sweep("dly2_s4", 4, -1, -1, ref_table(8'hFC, 4, 2));
    sel = 1;
    run_sweep("dly2_s3", 3, -1, -1, ref_table(8'hFC, 3, 2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
